// File: rtl/cmd_parser_pkg.sv
// cmd_parser_pkg
// Shared definitions for the button packet parser: FSM state encoding,
// protocol byte constants and a key-character range helper.
// Optional feature macro: CMD_PARSER_CHECKSUM_EN (adds the CHK state).
package cmd_parser_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BANG,
    CMD,
    KEY
`ifdef CMD_PARSER_CHECKSUM_EN
    , CHK
`endif
  } state_t;

  localparam logic [7:0] CH_BANG = 8'h21;  // '!'
  localparam logic [7:0] CH_B_UP = 8'h42;  // 'B'
  localparam logic [7:0] CH_B_LO = 8'h62;  // 'b'
  localparam logic [7:0] CH_ZERO = 8'h30;  // '0'
  localparam logic [7:0] CH_ONE  = 8'h31;  // '1'

  // True for '1' .. '0'+num_keys
  function automatic logic is_key_char(input logic [7:0] b, input int num_keys);
    logic [8:0] hi;
    hi = 9'(CH_ZERO) + 9'(num_keys);
    return (b > CH_ZERO) && ({1'b0, b} <= hi);
  endfunction

endpackage

// File: rtl/button_packet_parser_byte_timeout.sv
// byte_timeout
// Inter-byte watchdog. A down-counter is reloaded on every consumed byte and
// counts down while enabled; expired is raised combinationally on the cycle
// whose closing edge is the TIMEOUT_CYCLES-th idle edge after the last byte.
// Ports:
//   clk     - clock
//   rst     - asynchronous active-high reset
//   clear   - reload the counter (a byte was consumed)
//   enable  - count (parser is mid-packet)
//   expired - terminal count reached while enabled
module byte_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= LOAD;
    end else if (enable && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign expired = enable && (r_cnt == '0);

endmodule

// File: rtl/button_packet_parser.sv
// button_packet_parser
// Parses key packets from a UART byte stream: '!', 'B'/'b', key char,
// press char ('0'/'1') and, when CMD_PARSER_CHECKSUM_EN is defined, a
// checksum byte equal to ~(sum of the four preceding bytes).
// Ports:
//   clk        - clock
//   rst        - asynchronous active-high reset
//   drive_line - byte strobe, one cycle per byte
//   data_in    - received byte
//   key_val    - 1-based key of last accepted packet
//   press      - press(1)/release(0) of last accepted packet
//   ready      - one-cycle pulse on acceptance
//   key_state  - held-key bitmap, bit k-1 for key k
//   err        - one-cycle pulse on malformed packet, bad checksum or timeout
// Optional feature macro: CMD_PARSER_CHECKSUM_EN
module button_packet_parser
  import cmd_parser_pkg::*;
#(
  parameter int NUM_KEYS       = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  localparam int KEY_W         = $clog2(NUM_KEYS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                drive_line,
  input  logic [7:0]          data_in,
  output logic [KEY_W-1:0]    key_val,
  output logic                press,
  output logic                ready,
  output logic [NUM_KEYS-1:0] key_state,
  output logic                err
);

  state_t r_state;
  state_t w_next_state;

  logic [KEY_W-1:0]    r_key;
  logic [KEY_W-1:0]    r_key_val;
  logic                r_press;
  logic                r_ready;
  logic                r_err;
  logic [NUM_KEYS-1:0] r_key_state;

  logic w_accept;
  logic w_err;
  logic w_latch_key;
  logic w_acc_press;
  logic w_expired;
  logic w_busy;

  assign w_busy = (r_state != IDLE);

  byte_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_byte_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (drive_line),
    .enable (w_busy),
    .expired(w_expired)
  );

`ifdef CMD_PARSER_CHECKSUM_EN
  logic       r_press_lat;
  logic [7:0] r_acc;
  logic       w_latch_press;

  assign w_acc_press = r_press_lat;
`else
  // Without checksum the press char is the final byte itself.
  assign w_acc_press = data_in[0];
`endif

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_err        = 1'b0;
    w_latch_key  = 1'b0;
`ifdef CMD_PARSER_CHECKSUM_EN
    w_latch_press = 1'b0;
`endif
    if (drive_line) begin
      case (r_state)
        IDLE: begin
          if (data_in == CH_BANG) w_next_state = BANG;
        end
        BANG: begin
          if ((data_in == CH_B_UP) || (data_in == CH_B_LO)) begin
            w_next_state = CMD;
          end else if (data_in != CH_BANG) begin
            w_err        = 1'b1;
            w_next_state = IDLE;
          end
        end
        CMD: begin
          if (is_key_char(data_in, NUM_KEYS)) begin
            w_latch_key  = 1'b1;
            w_next_state = KEY;
          end else if (data_in == CH_BANG) begin
            w_err        = 1'b1;
            w_next_state = BANG;
          end else begin
            w_err        = 1'b1;
            w_next_state = IDLE;
          end
        end
        KEY: begin
          if ((data_in == CH_ZERO) || (data_in == CH_ONE)) begin
`ifdef CMD_PARSER_CHECKSUM_EN
            w_latch_press = 1'b1;
            w_next_state  = CHK;
`else
            w_accept      = 1'b1;
            w_next_state  = IDLE;
`endif
          end else begin
            w_err        = 1'b1;
            w_next_state = IDLE;
          end
        end
`ifdef CMD_PARSER_CHECKSUM_EN
        CHK: begin
          if (data_in == ~r_acc) w_accept = 1'b1;
          else                   w_err    = 1'b1;
          w_next_state = IDLE;
        end
`endif
        default: w_next_state = IDLE;
      endcase
    end else if (w_expired) begin
      // A byte on the expiry cycle takes priority over the timeout.
      w_err        = 1'b1;
      w_next_state = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key       <= '0;
      r_key_val   <= '0;
      r_press     <= 1'b0;
      r_ready     <= 1'b0;
      r_err       <= 1'b0;
      r_key_state <= '0;
    end else begin
      r_ready <= w_accept;
      r_err   <= w_err;
      if (w_latch_key) r_key <= KEY_W'(data_in - CH_ZERO);
      if (w_accept) begin
        r_key_val <= r_key;
        r_press   <= w_acc_press;
        for (int k = 0; k < NUM_KEYS; k++) begin
          if (r_key == KEY_W'(k + 1)) r_key_state[k] <= w_acc_press;
        end
      end
    end
  end

`ifdef CMD_PARSER_CHECKSUM_EN
  // Every '!' that lands in BANG restarts the sum; other bytes accumulate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_press_lat <= 1'b0;
    end else if (drive_line) begin
      r_acc <= (w_next_state == BANG) ? CH_BANG : r_acc + data_in;
      if (w_latch_press) r_press_lat <= data_in[0];
    end
  end
`endif

  assign key_val   = r_key_val;
  assign press     = r_press;
  assign ready     = r_ready;
  assign err       = r_err;
  assign key_state = r_key_state;

endmodule

// File: tb/tb_button_packet_parser.sv
// tb_button_packet_parser
// Directed bench for button_packet_parser with NUM_KEYS=8 and a short
// timeout. Follows CMD_PARSER_CHECKSUM_EN to choose packet format.
module tb_button_packet_parser;

  localparam int NUM_KEYS = 8;
  localparam int TIMEOUT  = 20;
  localparam int KEY_W    = $clog2(NUM_KEYS + 1);

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                drive_line = 1'b0;
  logic [7:0]          data_in = 8'h00;
  logic [KEY_W-1:0]    key_val;
  logic                press;
  logic                ready;
  logic [NUM_KEYS-1:0] key_state;
  logic                err;

  int   n_checks = 0;
  int   n_errors = 0;
  logic got_ready;
  logic got_err;
  logic [7:0] exp_ks;

  button_packet_parser #(
    .NUM_KEYS      (NUM_KEYS),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .drive_line(drive_line),
    .data_in   (data_in),
    .key_val   (key_val),
    .press     (press),
    .ready     (ready),
    .key_state (key_state),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    drive_line = 1'b1;
    data_in    = b;
    @(posedge clk);
    #1;
    drive_line = 1'b0;
    got_ready  = ready;
    got_err    = err;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] csum(input logic [7:0] a, b, c, d);
    logic [7:0] s;
    s = a + b + c + d;
    return ~s;
  endfunction

  task automatic send_pkt(input logic [7:0] c, input logic [7:0] k, input logic [7:0] p);
    send_byte(8'h21);
    send_byte(c);
    send_byte(k);
    send_byte(p);
`ifdef CMD_PARSER_CHECKSUM_EN
    send_byte(csum(8'h21, c, k, p));
`endif
  endtask

  task automatic check_accept(input string tag, input int kv, input logic pr, input logic [7:0] ks);
    check({tag, "_ready"}, 32'(got_ready), 32'd1);
    check({tag, "_err"},   32'(got_err),   32'd0);
    check({tag, "_key"},   32'(key_val),   32'(kv));
    check({tag, "_press"}, 32'(press),     32'(pr));
    check({tag, "_ks"},    32'(key_state), 32'(ks));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_key"},   32'(key_val),   32'd0);
    check({tag, "_press"}, 32'(press),     32'd0);
    check({tag, "_ready"}, 32'(ready),     32'd0);
    check({tag, "_ks"},    32'(key_state), 32'd0);
    check({tag, "_err"},   32'(err),       32'd0);
  endtask

  initial begin
    exp_ks = 8'h00;
    idle(3);
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // "!B30" -> key 3 released
    send_pkt(8'h42, 8'h33, 8'h30);
    check_accept("b30", 3, 1'b0, exp_ks);
    idle(1);
    check("ready_one_cycle", 32'(ready), 32'd0);

    // "!b51" -> key 5 pressed, then "!B50" releases it
    send_pkt(8'h62, 8'h35, 8'h31);
    exp_ks = 8'h10;
    check_accept("b51", 5, 1'b1, exp_ks);
    send_pkt(8'h42, 8'h35, 8'h30);
    exp_ks = 8'h00;
    check_accept("b50", 5, 1'b0, exp_ks);

`ifdef CMD_PARSER_CHECKSUM_EN
    // Known-good literal checksum, then a bad one
    send_byte(8'h21); send_byte(8'h42); send_byte(8'h33); send_byte(8'h30);
    send_byte(8'h39);
    check_accept("chk_good", 3, 1'b0, exp_ks);
    send_byte(8'h21); send_byte(8'h42); send_byte(8'h35); send_byte(8'h31);
    send_byte(8'h00);
    check("chk_bad_err", 32'(got_err), 32'd1);
    check("chk_bad_ready", 32'(got_ready), 32'd0);
    check("chk_bad_ks", 32'(key_state), 32'(exp_ks));
`else
    // Fifth byte '!' starts a new packet
    send_byte(8'h21); send_byte(8'h42); send_byte(8'h34); send_byte(8'h31);
    exp_ks = 8'h08;
    check_accept("pkt_a", 4, 1'b1, exp_ks);
    send_byte(8'h21);
    check("fifth_err", 32'(got_err), 32'd0);
    send_byte(8'h42); send_byte(8'h36); send_byte(8'h31);
    exp_ks = 8'h28;
    check_accept("pkt_b", 6, 1'b1, exp_ks);
`endif

    // "!B9" out of range
    send_byte(8'h21); send_byte(8'h42); send_byte(8'h39);
    check("key9_err", 32'(got_err), 32'd1);
    check("key9_ready", 32'(got_ready), 32'd0);

    // "!!B21" -> key 2 pressed
    send_byte(8'h21);
    send_byte(8'h21);
    check("dbl_bang_err", 32'(got_err), 32'd0);
    send_byte(8'h42); send_byte(8'h32); send_byte(8'h31);
`ifdef CMD_PARSER_CHECKSUM_EN
    send_byte(csum(8'h21, 8'h42, 8'h32, 8'h31));
`endif
    exp_ks = exp_ks | 8'h02;
    check_accept("dbl_bang", 2, 1'b1, exp_ks);

    // Repeated press of a held key
    send_pkt(8'h42, 8'h32, 8'h31);
    check_accept("repeat", 2, 1'b1, exp_ks);

    // Timeout after "!B"
    send_byte(8'h21); send_byte(8'h42);
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      idle(1);
      check("to_early_err", 32'(err), 32'd0);
    end
    idle(1);
    check("to_err", 32'(err), 32'd1);
    check("to_ready", 32'(ready), 32'd0);
    idle(1);
    check("to_err_pulse", 32'(err), 32'd0);
    send_byte(8'h33);
    check("to_after3", 32'({got_ready, got_err}), 32'd0);
    send_byte(8'h31);
    check("to_after1", 32'({got_ready, got_err}), 32'd0);

    // Byte on the expiry cycle wins
    send_byte(8'h21); send_byte(8'h42);
    idle(TIMEOUT - 1);
    send_byte(8'h33);
    check("race_err", 32'(got_err), 32'd0);
    send_byte(8'h31);
`ifdef CMD_PARSER_CHECKSUM_EN
    send_byte(csum(8'h21, 8'h42, 8'h33, 8'h31));
`endif
    exp_ks = exp_ks | 8'h04;
    check_accept("race", 3, 1'b1, exp_ks);

    // Reset mid-packet, byte strobed during reset
    send_byte(8'h21); send_byte(8'h42); send_byte(8'h33);
    @(negedge clk);
    rst        = 1'b1;
    drive_line = 1'b1;
    data_in    = 8'h21;
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    #1;
    drive_line = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h31);
    check("post_rst_ready", 32'(got_ready), 32'd0);
    check("post_rst_err", 32'(got_err), 32'd0);

    send_pkt(8'h42, 8'h37, 8'h31);
    check_accept("post_rst_pkt", 7, 1'b1, 8'h40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/button_packet_parser.md
BUTTON_PACKET_PARSER -- requirements
Module: button_packet_parser

Interface
REQ-001 Parameter NUM_KEYS, default 8, meaning number of accepted key codes ('1'..'0'+NUM_KEYS), legal range 1..9.
REQ-002 Parameter TIMEOUT_CYCLES, default 1_000_000, meaning maximum clk cycles between bytes of one packet.
REQ-003 Derived constant KEY_W = $clog2(NUM_KEYS+1).
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 drive_line  input  1  byte strobe from the UART receiver, one clk cycle per byte.
REQ-007 data_in  input  8  received byte, valid when drive_line=1.
REQ-008 key_val  output  KEY_W  1-based key number of the last accepted packet.
REQ-009 press  output  1  press(1)/release(0) of the last accepted packet.
REQ-010 ready  output  1  one-cycle pulse: key_val/press updated this cycle.
REQ-011 key_state  output  NUM_KEYS  held-key bitmap; bit k-1 set while key k is pressed.
REQ-012 err  output  1  one-cycle pulse on malformed packet, checksum mismatch or timeout.

Function
REQ-013 Packet format SHALL be '!' (0x21), 'B' (0x42) or 'b' (0x62), key char, press char ('0'/'1'), then a checksum byte when CMD_PARSER_CHECKSUM_EN is defined.
REQ-014 FSM states SHALL be IDLE, BANG, CMD, KEY, CHK; bytes are consumed only on cycles with drive_line=1.
REQ-015 IDLE: '!' goes to BANG; any other byte is discarded silently.
REQ-016 BANG: 'B'/'b' goes to CMD; '!' stays in BANG; anything else pulses err and goes to IDLE.
REQ-017 CMD: key char in '1'..'0'+NUM_KEYS is latched and the FSM goes to KEY; '!' goes to BANG with err; anything else pulses err and goes to IDLE.
REQ-018 KEY: '0'/'1' is latched, and the FSM goes to CHK (checksum on) or accepts the packet (checksum off) and returns to IDLE; any other byte pulses err and goes to IDLE.
REQ-019 CHK: a byte equal to ~(sum of the four preceding bytes, mod 256) accepts the packet; a mismatch pulses err; both return to IDLE. '!' is treated as data here.
REQ-020 Acceptance SHALL, on the clk edge that consumes the final byte, update key_val, press and key_state[key-1] and assert ready for exactly one cycle, for one cycle of latency.
REQ-021 The inter-byte counter SHALL reset on every consumed byte and count while the FSM is outside IDLE; reaching TIMEOUT_CYCLES pulses err and forces IDLE.
REQ-022 A timeout and a byte on the same cycle: the byte wins and the counter restarts.
REQ-023 err and ready SHALL never be asserted in the same cycle.
REQ-024 Repeated press of an already-held key SHALL still pulse ready, with key_state unchanged.

Reset
REQ-025 rst=1 SHALL immediately force the FSM to IDLE and clear the checksum accumulator, the timeout counter, key_val, press, ready, key_state and err, including mid-packet.
REQ-026 Bytes strobed while rst=1 SHALL be ignored; a packet interrupted by reset is dropped without err.

Configuration
REQ-027 Macro CMD_PARSER_CHECKSUM_EN defined: the CHK state and 8-bit accumulator are compiled in and the packet is 5 bytes.
REQ-028 Macro absent: CHK and the accumulator are removed, the packet is 4 bytes, and a fifth byte is processed as a new IDLE byte.

Structure
REQ-029 A shared package cmd_parser_pkg SHALL hold the state enum and byte constants (CH_BANG, CH_B_UP, CH_B_LO, CH_ZERO, CH_ONE).
REQ-030 The timeout counter SHALL be a sub-module byte_timeout (inputs clk, rst, clear, enable; output expired).

Verification
REQ-031 Checksum off: "!B30" -> ready pulse, key_val=3, press=0, key_state=0x00.
REQ-032 Checksum off: "!b51" -> key_val=5, press=1, key_state=0x10; then "!B50" -> key_state=0x00.
REQ-033 Checksum on: "!B30"+0x39 -> ready; "!B51"+0x00 -> err pulse, key_state unchanged.
REQ-034 "!B9" (NUM_KEYS=8) -> err, IDLE; "!!B21" -> key_val=2, press=1, ready.
REQ-035 "!B" then idle TIMEOUT_CYCLES -> err at that cycle; next "31" bytes ignored, no ready.
REQ-036 rst pulsed after "!B3" -> all outputs 0; the following "1" byte gives no ready and no err.
